// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;
  typedef logic [7:0] byte_t;

  typedef enum logic [2:0] {
    IDLE,
    PULSE,
    WAIT_HI,
    WAIT_LO,
    GAP
  } feeder_state_e;

  localparam byte_t ASCII_CR   = 8'h0D;
  localparam byte_t ASCII_LF   = 8'h0A;
  localparam byte_t ASCII_ZERO = 8'h30;
endpackage

// File: rtl/uart_tx_feeder_if.sv
// Upstream byte handshake plus the uart_tx request/busy pair and feeder status.
interface uart_tx_feeder_if #(parameter int DEPTH = 16);
  import uart_pkg::*;

  logic                   in_valid;
  byte_t                  in_byte;
  logic                   in_ready;
  logic                   tx_dv;
  byte_t                  tx_byte;
  logic                   tx_busy;
  logic [$clog2(DEPTH):0] level;
  logic                   idle;
  logic                   timeout_err;

  // slave = the feeder, master = upstream producer plus uart_tx
  modport slave (
    input  in_valid, in_byte, tx_busy,
    output in_ready, tx_dv, tx_byte, level, idle, timeout_err
  );
  modport master (
    output in_valid, in_byte, tx_busy,
    input  in_ready, tx_dv, tx_byte, level, idle, timeout_err
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock circular FIFO; pointers carry one extra wrap bit to tell full from empty.
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // storage is not reset; stale entries are unreachable once the pointers clear
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  assign level = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (level == (AW+1)'(DEPTH));
  assign rdata = mem[rd_ptr[AW-1:0]];
endmodule

// File: rtl/uart_tx_feeder.sv
// Queues upstream bytes and hands them to uart_tx one frame at a time with an idle gap.
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int DEPTH        = 16,
  parameter int CLKS_PER_BIT = 868,
  parameter int GAP_BITS     = 1,
  parameter int BUSY_TIMEOUT = 4   // must be >= 2
) (
  input  logic              clk,
  input  logic              reset,
  uart_tx_feeder_if.slave   bus
);
  localparam int AW       = $clog2(DEPTH);
  localparam int GAP_CLKS = GAP_BITS * CLKS_PER_BIT;
  localparam int CNT_MAX  = (GAP_CLKS > BUSY_TIMEOUT) ? GAP_CLKS : BUSY_TIMEOUT;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);
  localparam int GAP_INIT = (GAP_CLKS > 0) ? GAP_CLKS - 1 : 0;
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_INIT);
  // one WAIT_HI cycle per count down to zero puts the error exactly BUSY_TIMEOUT clocks after tx_dv
  localparam logic [CNT_W-1:0] TMO_LOAD = CNT_W'(BUSY_TIMEOUT - 2);

  feeder_state_e    state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             pop, dv_nxt, err_set;
  logic             tx_dv_q, err_q;
  byte_t            tx_byte_q, head;
  logic             full, empty;
  logic [AW:0]      fifo_level;

  sync_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (bus.in_valid && !full),
    .wdata (bus.in_byte),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!empty && !bus.tx_busy) state_nxt = PULSE;
      PULSE:   state_nxt = WAIT_HI;
      WAIT_HI: begin
        if (bus.tx_busy)   state_nxt = WAIT_LO;
        else if (cnt == 0) state_nxt = (GAP_CLKS == 0) ? IDLE : GAP;
      end
      WAIT_LO: if (!bus.tx_busy) state_nxt = (GAP_CLKS == 0) ? IDLE : GAP;
      GAP:     if (cnt == 0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // single counter shared between busy timeout and inter-frame gap
  always_comb begin
    pop     = 1'b0;
    dv_nxt  = 1'b0;
    err_set = 1'b0;
    cnt_nxt = cnt;
    case (state)
      IDLE: if (state_nxt == PULSE) begin
        pop    = 1'b1;
        dv_nxt = 1'b1;
      end
      PULSE:   cnt_nxt = TMO_LOAD;
      WAIT_HI: if (!bus.tx_busy) begin
        if (cnt == 0) begin
          err_set = 1'b1;
          cnt_nxt = GAP_LOAD;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      WAIT_LO: if (!bus.tx_busy) cnt_nxt = GAP_LOAD;
      GAP:     if (cnt != 0) cnt_nxt = cnt - 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      tx_dv_q   <= 1'b0;
      tx_byte_q <= 8'h00;
      err_q     <= 1'b0;
    end else begin
      cnt     <= cnt_nxt;
      tx_dv_q <= dv_nxt;
      if (pop)     tx_byte_q <= head;
      if (err_set) err_q     <= 1'b1;
    end
  end

  assign bus.in_ready    = !full;
  assign bus.tx_dv       = tx_dv_q;
  assign bus.tx_byte     = tx_byte_q;
  assign bus.level       = fifo_level;
  assign bus.idle        = empty && (state == IDLE);
  assign bus.timeout_err = err_q;
endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder with a behavioural uart_tx stub driving tx_busy.
module tb_uart_tx_feeder;
  import uart_pkg::*;

  localparam int CPB = 4;
  localparam int GB  = 1;
  localparam int BT  = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  uart_tx_feeder_if #(.DEPTH(16)) bus();

  uart_tx_feeder #(.DEPTH(16), .CLKS_PER_BIT(CPB), .GAP_BITS(GB), .BUSY_TIMEOUT(BT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;

  // uart_tx stub: on an accepted tx_dv it records the byte and holds busy for a 10-bit frame
  logic  stub_en = 1'b1;
  logic  force_busy = 1'b0;
  logic  sbusy = 1'b0;
  int    bcnt = 0;
  int    cyc = 0;
  int    last_fall = -100000;
  int    viol = 0;
  int    gapviol = 0;
  byte_t rx_q[$];
  int    dv_cyc[$];

  assign bus.tx_busy = sbusy | force_busy;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) begin
      sbusy <= 1'b0;
      bcnt  <= 0;
    end else begin
      if (bus.tx_dv) begin
        dv_cyc.push_back(cyc);
        if (bus.tx_busy) viol <= viol + 1;
        if (cyc - last_fall < GB * CPB) gapviol <= gapviol + 1;
        if (stub_en && !sbusy) begin
          rx_q.push_back(bus.tx_byte);
          sbusy <= 1'b1;
          bcnt  <= 10 * CPB;
        end
      end else if (bcnt != 0) begin
        bcnt <= bcnt - 1;
        if (bcnt == 1) begin
          sbusy     <= 1'b0;
          last_fall <= cyc;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push_bytes(input int n, input byte_t b0, input byte_t b1,
                            input byte_t b2, input byte_t b3);
    byte_t b[4];
    b[0] = b0; b[1] = b1; b[2] = b2; b[3] = b3;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_byte  = b[i];
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_rx(input int n, input int budget, input string name);
    int t = 0;
    while (rx_q.size() < n && t < budget) begin
      @(negedge clk);
      t++;
    end
    chk(name, rx_q.size() >= n, 1);
  endtask

  task automatic wait_idle(input string name);
    int t = 0;
    while (!bus.idle && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk(name, bus.idle, 1'b1);
  endtask

  typedef struct {
    byte_t data;
    byte_t exp_byte;
    logic [4:0] exp_level;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int n0, acc, t;

    vecs[0] = '{8'h55, 8'h55, 5'd1};
    vecs[1] = '{8'h00, 8'h00, 5'd1};
    vecs[2] = '{8'hFF, 8'hFF, 5'd1};
    vecs[3] = '{ASCII_ZERO, 8'h30, 5'd1};

    bus.in_valid = 1'b0;
    bus.in_byte  = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_level",    bus.level, 0);
    chk("rst_tx_dv",    bus.tx_dv, 0);
    chk("rst_tx_byte",  bus.tx_byte, 8'h00);
    chk("rst_tmo",      bus.timeout_err, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_idle",     bus.idle, 1);

    // single bytes: 2-clock latency, one-cycle pulse, stub receives the byte
    for (int i = 0; i < 4; i++) begin
      rx_q.delete();
      push_bytes(1, vecs[i].data, 8'h00, 8'h00, 8'h00);
      chk("single_level_push", bus.level, vecs[i].exp_level);
      chk("single_dv_early",   bus.tx_dv, 0);
      chk("single_busy_idle",  bus.idle, 0);
      @(negedge clk);
      chk("single_dv",      bus.tx_dv, 1);
      chk("single_tx_byte", bus.tx_byte, vecs[i].exp_byte);
      chk("single_level_pop", bus.level, 0);
      @(negedge clk);
      chk("single_dv_once", bus.tx_dv, 0);
      wait_rx(1, 200, "single_rx_timeout");
      chk("single_rx_byte", rx_q[0], vecs[i].exp_byte);
      wait_idle("single_idle");
    end

    // burst: '7', CR, LF in order with full frame + gap spacing
    rx_q.delete();
    n0 = dv_cyc.size();
    push_bytes(3, 8'h37, ASCII_CR, ASCII_LF, 8'h00);
    wait_rx(3, 600, "burst_rx_timeout");
    chk("burst_b0", rx_q[0], 8'h37);
    chk("burst_b1", rx_q[1], 8'h0D);
    chk("burst_b2", rx_q[2], 8'h0A);
    chk("burst_space01", (dv_cyc[n0+1] - dv_cyc[n0]) >= (10 + GB) * CPB, 1);
    chk("burst_space12", (dv_cyc[n0+2] - dv_cyc[n0+1]) >= (10 + GB) * CPB, 1);
    wait_idle("burst_idle");

    // push landing on the pop cycle keeps level at 1
    rx_q.delete();
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_byte  = 8'hC3;
    @(negedge clk);
    chk("conc_level_a", bus.level, 1);
    bus.in_byte = 8'h3C;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("conc_level_b", bus.level, 1);
    chk("conc_dv",      bus.tx_dv, 1);
    chk("conc_tx_byte", bus.tx_byte, 8'hC3);
    wait_rx(2, 300, "conc_rx_timeout");
    chk("conc_b0", rx_q[0], 8'hC3);
    chk("conc_b1", rx_q[1], 8'h3C);
    wait_idle("conc_idle");

    // fill with uart_tx stalled
    rx_q.delete();
    force_busy = 1'b1;
    n0 = dv_cyc.size();
    acc = 0;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      if (bus.in_ready) acc++;
      bus.in_valid = 1'b1;
      bus.in_byte  = byte_t'(8'hA0 + i);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("fill_accepted", acc, 16);
    chk("fill_level",    bus.level, 16);
    chk("fill_in_ready", bus.in_ready, 0);
    repeat (10) @(negedge clk);
    chk("fill_no_dv", dv_cyc.size() - n0, 0);
    force_busy = 1'b0;
    wait_rx(16, 2000, "fill_rx_timeout");
    for (int i = 0; i < 16; i++) chk("fill_order", rx_q[i], 8'hA0 + i);
    wait_idle("fill_idle");

    // stub ignores tx_dv: sticky error exactly BT clocks later, next byte still goes out
    rx_q.delete();
    stub_en = 1'b0;
    push_bytes(2, 8'h11, 8'h22, 8'h00, 8'h00);
    t = 0;
    while (!bus.tx_dv && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("tmo_dv_seen", bus.tx_dv, 1);
    for (int k = 1; k < BT; k++) begin
      @(negedge clk);
      chk("tmo_not_yet", bus.timeout_err, 0);
    end
    @(negedge clk);
    chk("tmo_set", bus.timeout_err, 1);
    stub_en = 1'b1;
    wait_rx(1, 200, "tmo_rx_timeout");
    chk("tmo_next_byte", rx_q[0], 8'h22);
    chk("tmo_sticky",    bus.timeout_err, 1);
    wait_idle("tmo_idle");

    // reset while waiting on busy with three bytes still queued
    rx_q.delete();
    push_bytes(4, 8'h41, 8'h42, 8'h43, 8'h44);
    t = 0;
    while (!bus.tx_busy && t < 50) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    chk("rstmid_level_pre", bus.level, 3);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rstmid_level", bus.level, 0);
    chk("rstmid_dv",    bus.tx_dv, 0);
    chk("rstmid_idle",  bus.idle, 1);
    chk("rstmid_tmo",   bus.timeout_err, 0);
    rx_q.delete();
    n0 = dv_cyc.size();
    repeat (300) @(negedge clk);
    chk("rstmid_no_dv", dv_cyc.size() - n0, 0);
    chk("rstmid_no_rx", rx_q.size(), 0);

    chk("dv_while_busy", viol, 0);
    chk("gap_after_busy", gapviol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_tx_feeder.md
Name: uart_tx_feeder

Overview:
Buffered byte source that drives the uart_tx request interface (tx_dv/tx_byte/tx_busy). Upstream logic pushes bytes with a valid/ready handshake, for example the classifier's ASCII result digit followed by CR/LF. The block queues them in a FIFO and issues one single-cycle tx_dv pulse per byte, with at least one configurable idle gap between frames. It sits between the result formatter and uart_tx in the top level.

Parameters:
DEPTH, 16, FIFO depth in bytes; power of two, ≥2
CLKS_PER_BIT, 868, clocks per UART bit; must match uart_tx
GAP_BITS, 1, minimum idle bit-times between a tx_busy fall and the next tx_dv
BUSY_TIMEOUT, 4, clocks to wait for tx_busy to rise after tx_dv before abandoning the byte

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  upstream byte valid
in_byte  input  8  upstream byte
in_ready  output  1  FIFO not full; a push happens when in_valid && in_ready
tx_dv  output  1  single-cycle start pulse to uart_tx
tx_byte  output  8  byte to uart_tx; stable from the tx_dv cycle until tx_busy falls
tx_busy  input  1  uart_tx busy
level  output  $clog2(DEPTH)+1  current FIFO occupancy
idle  output  1  FIFO empty and FSM in IDLE
timeout_err  output  1  sticky flag: a tx_dv pulse was never acknowledged by tx_busy

Behaviour:
- Single clock domain. All outputs registered except in_ready, level and idle, which are decoded from registers.
- Values at reset:
  - FIFO empty, pointers 0, level=0.
  - tx_dv=0, tx_byte=8'h00, timeout_err=0.
  - in_ready=1, idle=1, FSM=IDLE.
- Reset asserted mid-frame: FIFO contents are dropped. The block does not wait for uart_tx, which shares the same reset.
- FIFO:
  - Circular buffer with pointers one bit wider than the address; the extra bit separates full from empty.
  - full when level==DEPTH; in_ready = !full.
  - Push and pop in the same cycle are both allowed when not empty. Pushing while full is impossible by handshake.
  - Simultaneous push and pop leaves level unchanged.
  - A push into an empty FIFO is visible to the FSM on the next cycle (first-byte latency of 2 clocks from push to tx_dv).
- FSM states:
  - IDLE: if level>0, pop the head into tx_byte and go to PULSE. Otherwise stay.
  - PULSE: tx_dv=1 for exactly this cycle. Load the timeout counter and go to WAIT_HI.
  - WAIT_HI: if tx_busy, go to WAIT_LO. If the counter reaches BUSY_TIMEOUT, set timeout_err and go to GAP (the byte is lost).
  - WAIT_LO: wait for !tx_busy, then load the gap counter with GAP_BITS*CLKS_PER_BIT-1 and go to GAP.
  - GAP: decrement the counter. At 0 go to IDLE. With GAP_BITS=0 the FSM goes to IDLE directly.
- tx_dv is never asserted while tx_busy=1 or in any state other than PULSE.
- If tx_busy is already high when the FSM reaches IDLE (an external sender), IDLE waits for !tx_busy before popping.
- Throughput: one byte per (10 + GAP_BITS)*CLKS_PER_BIT + ~4 clocks.
- Byte order is strict FIFO. No byte is ever duplicated.

Decomposition:
- Package uart_pkg:
  - byte_t (logic [7:0]).
  - Feeder FSM state enum: IDLE, PULSE, WAIT_HI, WAIT_LO, GAP.
  - Constants ASCII_CR=8'h0D, ASCII_LF=8'h0A, ASCII_ZERO=8'h30.
- One sub-module, sync_fifo (DEPTH, WIDTH; push/pop/full/empty/level).
- The FSM and counters live in uart_tx_feeder.

Test Plan:
- Single byte: push 8'h55 into an idle block → tx_dv pulses for 1 clock 2 clocks later with tx_byte=8'h55. A loopback uart_rx yields rx_byte=8'h55. idle returns to 1.
- Burst: push "7", CR, LF back-to-back, 3 cycles → rx receives 8'h37, 8'h0D, 8'h0A in order. Each tx_dv rising edge is at least (10+1)*CLKS_PER_BIT clocks after the previous one.
- Fill: push 17 bytes with uart_tx stalled (tx_busy forced high) → in_ready drops after 16 pushes and level=16. No tx_dv while busy. Releasing busy drains all 16 bytes in order.
- Concurrent push and pop: push on the same cycle the FSM pops with level=1 → level stays 1 and the byte order is preserved.
- Timeout: a stub that never raises tx_busy → timeout_err=1 exactly BUSY_TIMEOUT clocks after the tx_dv pulse. The next queued byte is still sent after the gap.
- Reset mid-frame: assert reset during WAIT_LO with 3 bytes queued → the next cycle shows level=0, tx_dv=0, idle=1, timeout_err=0. No stale byte is sent afterwards.
